mult4_seq_ctrl: RTL



---
 rtl/mult4_seq_pkg.sv | 23 ++
 rtl/mult4_seq_idx_cnt.sv | 64 ++++++
 rtl/mult4_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mult4_seq_pkg.sv
// Shared types and helpers for the nibble-serial multiplier sequencer.
// Optional build macro used by the RTL: MULT4_SEQ_ZERO_SKIP_EN.
package mult4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CORE_W  = 4;
  localparam int CORE_OW = 8;

  function automatic int nib_count(input int n);
    return n / CORE_W;
  endfunction

  // A single-nibble operand still needs a 1-bit index so that ports stay legal.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/mult4_seq_idx_cnt.sv
// 2-D nibble index counter (i = row over a, j = column over b) with end flags.
// With MULT4_SEQ_ZERO_SKIP_EN defined, skip_row_i retires a whole row in one step.
module mult4_seq_idx_cnt
  import mult4_seq_pkg::*;
#(
  parameter int NIB = 2,
  localparam int IW = idx_width(NIB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
`ifdef MULT4_SEQ_ZERO_SKIP_EN
  input  logic          skip_row_i,
`endif
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic          row_last_o,
  output logic          last_o
);

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;

  assign row_last_o = (i_q == IW'(NIB - 1));
  assign last_o     = row_last_o && (j_q == IW'(NIB - 1));
  assign i_o        = i_q;
  assign j_o        = j_q;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (en_i) begin
`ifdef MULT4_SEQ_ZERO_SKIP_EN
      if (skip_row_i) begin
        i_d = row_last_o ? '0 : i_q + 1'b1;
        j_d = '0;
      end else
`endif
      if (j_q == IW'(NIB - 1)) begin
        i_d = row_last_o ? '0 : i_q + 1'b1;
        j_d = '0;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/mult4_seq_ctrl.sv
// N x N unsigned multiplier sequencer time-sharing one external 4x4 core.
// Optional build macro: MULT4_SEQ_ZERO_SKIP_EN (zero-operand and zero-row skipping).
module mult4_seq_ctrl
  import mult4_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [N-1:0]         in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N-1:0]       out_p,
  output logic                 busy,
  output logic [CORE_W-1:0]    core_x,
  output logic [CORE_W-1:0]    core_y,
  input  logic [CORE_OW-1:0]   core_o
);

  localparam int NIB = nib_count(N);
  localparam int IW  = idx_width(NIB);
  localparam int PW  = 2 * N;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;

  logic [IW-1:0]     i_idx, j_idx;
  logic              row_last, last;
  logic              accept;
  logic [CORE_W-1:0] nib_a, nib_b;

  assign accept = in_valid && (state_q == IDLE);
  assign nib_a  = a_q[CORE_W*i_idx +: CORE_W];
  assign nib_b  = b_q[CORE_W*j_idx +: CORE_W];

`ifdef MULT4_SEQ_ZERO_SKIP_EN
  logic row_zero, zero_op;
  assign row_zero = (nib_a == '0);
  assign zero_op  = (in_a == '0) || (in_b == '0);
`endif

  mult4_seq_idx_cnt #(.NIB(NIB)) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .en_i       (state_q == CALC),
`ifdef MULT4_SEQ_ZERO_SKIP_EN
    .skip_row_i (row_zero),
`endif
    .i_o        (i_idx),
    .j_o        (j_idx),
    .row_last_o (row_last),
    .last_o     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MULT4_SEQ_ZERO_SKIP_EN
          state_d = zero_op ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
`ifdef MULT4_SEQ_ZERO_SKIP_EN
        if (row_zero && row_last) state_d = DONE;
        else
`endif
        if (last) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Partial product lands at nibble weight i+j; the running sum never exceeds 2N bits.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (accept) begin
      a_d   = in_a;
      b_d   = in_b;
      acc_d = '0;
    end else if (state_q == CALC
`ifdef MULT4_SEQ_ZERO_SKIP_EN
                 && !row_zero
`endif
                ) begin
      acc_d = acc_q + (PW'(core_o) << (CORE_W * (int'(i_idx) + int'(j_idx))));
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
    core_x    = (state_q == CALC) ? nib_a : '0;
    core_y    = (state_q == CALC) ? nib_b : '0;
    out_p     = acc_q;
  end

endmodule
